compute_sequencer: RTL and testbench
====================================

# compute_sequencer

Top-level run controller for the convolution test datapath. On a `start_i` pulse it sequences the whole run:
- one capture strobe into the operand/result memory;
- each enabled compute engine (single PE, 3x3 systolic array, 2x2 systolic array) launched in fixed order, one at a time;
- the shared result bus steered to the memory, with that engine's result-write strobe pulsed.

It also provides per-engine timeout detection and run status for the display/host side.

## Interface
Parameters:
- `TIMEOUT` — default 200 — maximum WAIT cycles per engine before abort; legal range 1..255.
- `TW` — default 8 — timer width; must satisfy 2^TW > TIMEOUT.

Ports. Engine index is 0 = PE, 1 = SA_3x3, 2 = SA_2x2.
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high.
- `start_i` in 1 — run request, sampled in IDLE only.
- `eng_en_i` in 3 — engine enable mask, latched when start is accepted.
- `capture_o` out 1 — memory operand-capture strobe (drives memory run-valid).
- `eng_start_o` out 3 — one-hot, single-cycle engine launch.
- `eng_done_i` in 3 — per-engine completion, level or pulse.
- `res_sel_o` out 2 — result-bus mux select to the memory c-inputs: 0 PE, 1 SA_3x3, 2 SA_2x2.
- `pe_valid_o` / `sa3_valid_o` / `sa2_valid_o` out 1 each — memory result-write strobes.
- `busy_o` out 1 — high whenever state ≠ IDLE.
- `done_o` out 1 — single-cycle end-of-run pulse.
- `err_o` out 1 — timeout occurred in the last run; sticky.
- `err_idx_o` out 2 — index of the engine that timed out.

## Operation
- States: IDLE, CAPTURE, LAUNCH, WAIT, WRITE, DONE. All outputs are Moore decodes of registered state.
- **IDLE**
  - `start_i`=1 → latch `eng_en_i` into `en_q`; go to CAPTURE.
  - `start_i` in any other state is ignored.
- **CAPTURE**
  - `capture_o`=1 for exactly this cycle.
  - Clear `err_o` and `err_idx_o`.
  - `idx` ← lowest set bit of `en_q`. If `en_q`=0, go to DONE; else go to LAUNCH.
- **LAUNCH**
  - `eng_start_o[idx]`=1, `res_sel_o`=`idx`.
  - Timer ← 0; go to WAIT.
- **WAIT**
  - `res_sel_o`=`idx`.
  - `eng_done_i[idx]`=1 → go to WRITE.
  - Else if timer = TIMEOUT−1 → `err_o`←1, `err_idx_o`←`idx`, go to DONE; remaining engines are skipped.
  - Else timer += 1.
  - `eng_done_i` bits other than `idx` are ignored. `eng_done_i` is not sampled in LAUNCH.
- **WRITE**
  - `res_sel_o`=`idx`; the strobe for `idx` (`pe_valid_o` / `sa3_valid_o` / `sa2_valid_o`) =1 for this cycle.
  - Next higher set bit of `en_q` → `idx`, go to LAUNCH. None left → DONE.
- **DONE**
  - `done_o`=1 for this cycle; go to IDLE.
- Invariants:
  - At most one of `capture_o`, `eng_start_o`, and the valid strobes is high in any cycle.
  - The valid strobes are mutually exclusive.
- `res_sel_o` holds its last value in IDLE/CAPTURE/DONE.

## Timing
- Reset values:
  - State IDLE; `en_q`=0; `idx`=0; timer=0.
  - All strobes 0; `res_sel_o`=0; `busy_o`=0; `done_o`=0; `err_o`=0; `err_idx_o`=0.
- Reset mid-run: returns to IDLE immediately. The in-flight engine is abandoned, no further strobes are issued, and `done_o` is not pulsed.
- Start latency: start sampled at edge 0 → `capture_o` high in cycle 1 → first `eng_start_o` in cycle 2.
- Per engine: minimum 3 cycles (LAUNCH, one WAIT, WRITE).
  - With done sampled in the Nth WAIT cycle, the WRITE strobe lands at LAUNCH+N+1.
- Full run, all enabled, done in first WAIT cycle: `done_o` in cycle 11; `busy_o` high cycles 1–11.
- Timeout: exactly TIMEOUT WAIT cycles are spent. If done arrives on the final WAIT cycle, done wins and no error is raised.
- `err_o` persists after DONE until the next CAPTURE.

## Test plan
- **Full run:** reset, `eng_en_i`=3'b111, start pulse; each engine raises done 1 cycle after its `eng_start_o`.
  - Required: `capture_o` in cycle 1.
  - Starts in cycles 2/5/8; `pe_valid_o`/`sa3_valid_o`/`sa2_valid_o` in cycles 4/7/10.
  - `res_sel_o` 0/1/2 during the respective LAUNCH–WRITE windows.
  - `done_o` in cycle 11; `err_o`=0.
- **Mask 3'b101:** only PE and SA_2x2 launched, SA_3x3 never strobed; `done_o` in cycle 8.
- **Mask 3'b000:** `capture_o` in cycle 1, `done_o` in cycle 2, no engine starts.
- **Timeout:** TIMEOUT=4, SA_3x3 never done.
  - Required: 4 WAIT cycles, then `done_o`; `err_o`=1, `err_idx_o`=1.
  - `pe_valid_o` seen once; `sa3_valid_o` and `sa2_valid_o` never seen, SA_2x2 never started.
  - Next start clears `err_o` in CAPTURE.
- **Done on last WAIT cycle:** TIMEOUT=4, done on the 4th WAIT cycle → WRITE occurs, `err_o`=0.
- **Start while busy / reset mid-WAIT:** extra `start_i` pulses during a run are ignored, giving exactly one `capture_o`. Reset asserted in WAIT → all outputs 0 next cycle, no `done_o`, and a new start runs normally.

Source files
------------

// File: rtl/compute_sequencer.sv
// Run controller for the convolution test datapath: captures operands, launches each
// enabled engine in order, steers its result into memory and watches for engine timeouts.
module compute_sequencer #(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [2:0] eng_en_i,
    output logic       capture_o,
    output logic [2:0] eng_start_o,
    input  logic [2:0] eng_done_i,
    output logic [1:0] res_sel_o,
    output logic       pe_valid_o,
    output logic       sa3_valid_o,
    output logic       sa2_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_idx_o
);

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    logic [2:0]    en_q;
    logic [1:0]    idx;
    logic [TW-1:0] timer;
    logic [2:0]    valid_q;
    logic [2:0]    first_pick;
    logic [2:0]    next_pick;

    // Lowest set bit of mask at or above lo, returned as {found, index}.
    function automatic logic [2:0] pick(input logic [2:0] mask, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_pick = pick(en_q, 3'd0);
    assign next_pick  = pick(en_q, {1'b0, idx} + 3'd1);

    assign pe_valid_o  = valid_q[0];
    assign sa3_valid_o = valid_q[1];
    assign sa2_valid_o = valid_q[2];

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            en_q        <= 3'b000;
            idx         <= 2'd0;
            timer       <= '0;
            capture_o   <= 1'b0;
            eng_start_o <= 3'b000;
            valid_q     <= 3'b000;
            res_sel_o   <= 2'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_idx_o   <= 2'd0;
        end else begin
            capture_o   <= 1'b0;
            eng_start_o <= 3'b000;
            valid_q     <= 3'b000;
            done_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        en_q      <= eng_en_i;
                        state     <= S_CAPTURE;
                        capture_o <= 1'b1;
                        busy_o    <= 1'b1;
                        err_o     <= 1'b0;
                        err_idx_o <= 2'd0;
                    end
                end
                S_CAPTURE: begin
                    if (first_pick[2]) begin
                        idx         <= first_pick[1:0];
                        res_sel_o   <= first_pick[1:0];
                        eng_start_o <= 3'b001 << first_pick[1:0];
                        state       <= S_LAUNCH;
                    end else begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done_i[idx]) begin
                        valid_q <= 3'b001 << idx;
                        state   <= S_WRITE;
                    end else if (timer == TIMER_LAST) begin
                        err_o     <= 1'b1;
                        err_idx_o <= idx;
                        done_o    <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WRITE: begin
                    if (next_pick[2]) begin
                        idx         <= next_pick[1:0];
                        res_sel_o   <= next_pick[1:0];
                        eng_start_o <= 3'b001 << next_pick[1:0];
                        state       <= S_LAUNCH;
                    end else begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compute_sequencer.sv
// Directed bench for compute_sequencer: cycle-numbered runs with a simple engine
// responder, checked with immediate assertions against hand-derived cycle numbers.
module tb_compute_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [2:0] eng_en_i;
    logic       capture_o;
    logic [2:0] eng_start_o;
    logic [2:0] eng_done_i;
    logic [1:0] res_sel_o;
    logic       pe_valid_o;
    logic       sa3_valid_o;
    logic       sa2_valid_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [1:0] err_idx_o;

    int checks = 0;
    int passes = 0;

    // Per-run observations, cycle numbers relative to the start-sampling edge.
    int cap_cnt, cap_cyc, done_cnt, done_cyc, busy_cnt, busy_first, viol;
    int err_c2, err_done, erridx_done, err_end;
    int st_cnt[3], st_cyc[3], val_cnt[3], val_cyc[3], sel_st[3], sel_val[3];

    compute_sequencer #(.TIMEOUT(4), .TW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .eng_en_i    (eng_en_i),
        .capture_o   (capture_o),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .res_sel_o   (res_sel_o),
        .pe_valid_o  (pe_valid_o),
        .sa3_valid_o (sa3_valid_o),
        .sa2_valid_o (sa2_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_idx_o   (err_idx_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Start a run with the given mask; engine i raises done in its d[i]-th WAIT cycle (0 = never).
    // Extra start pulses are driven in cycles x1/x2; stop_at > 0 abandons the run in that cycle.
    task automatic run_seq(input logic [2:0] mask, input int d0, input int d1, input int d2,
                           input int x1, input int x2, input int stop_at);
        int d[3];
        int s[3];
        logic [2:0] vld;
        int nstr;
        d = '{d0, d1, d2};
        s = '{0, 0, 0};
        cap_cnt = 0; cap_cyc = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1;
        viol = 0; err_c2 = -1; err_done = -1; erridx_done = -1; err_end = -1;
        for (int i = 0; i < 3; i++) begin
            st_cnt[i] = 0; st_cyc[i] = -1; val_cnt[i] = 0; val_cyc[i] = -1;
            sel_st[i] = -1; sel_val[i] = -1;
        end
        @(negedge clk);
        start_i    = 1'b1;
        eng_en_i   = mask;
        eng_done_i = 3'b000;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start_i = (k == x1) || (k == x2);
            vld = {sa2_valid_o, sa3_valid_o, pe_valid_o};
            if (capture_o) begin
                cap_cnt++;
                if (cap_cyc < 0) cap_cyc = k;
            end
            for (int i = 0; i < 3; i++) begin
                if (eng_start_o[i]) begin
                    st_cnt[i]++; st_cyc[i] = k; s[i] = k; sel_st[i] = int'(res_sel_o);
                end
                if (vld[i]) begin
                    val_cnt[i]++; val_cyc[i] = k; sel_val[i] = int'(res_sel_o);
                end
            end
            nstr = int'(capture_o) + $countones(eng_start_o) + $countones(vld);
            if (nstr > 1) viol++;
            if (busy_o) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
            end
            if (k == 2) err_c2 = int'(err_o);
            if (done_o) begin
                done_cnt++; done_cyc = k; err_done = int'(err_o); erridx_done = int'(err_idx_o);
            end
            for (int i = 0; i < 3; i++)
                eng_done_i[i] = (s[i] > 0) && (d[i] > 0) && (k == s[i] + d[i]);
            if (stop_at == k) break;
            if (done_cyc > 0 && k == done_cyc + 2) begin
                err_end = int'(err_o);
                break;
            end
        end
        start_i    = 1'b0;
        eng_done_i = 3'b000;
    endtask

    initial begin
        reset      = 1'b1;
        start_i    = 1'b0;
        eng_en_i   = 3'b000;
        eng_done_i = 3'b000;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            int'({capture_o, eng_start_o, pe_valid_o, sa3_valid_o, sa2_valid_o,
                  busy_o, done_o, err_o, err_idx_o, res_sel_o}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Full run, all engines, done in the first WAIT cycle.
        run_seq(3'b111, 1, 1, 1, 0, 0, 0);
        chk("full_cap_cyc", cap_cyc, 1);
        chk("full_start0", st_cyc[0], 2);
        chk("full_start1", st_cyc[1], 5);
        chk("full_start2", st_cyc[2], 8);
        chk("full_valid0", val_cyc[0], 4);
        chk("full_valid1", val_cyc[1], 7);
        chk("full_valid2", val_cyc[2], 10);
        chk("full_sel_st", sel_st[0] * 100 + sel_st[1] * 10 + sel_st[2], 12);
        chk("full_sel_val", sel_val[0] * 100 + sel_val[1] * 10 + sel_val[2], 12);
        chk("full_done_cyc", done_cyc, 11);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_busy_cnt", busy_cnt, 11);
        chk("full_busy_first", busy_first, 1);
        chk("full_err", err_done, 0);
        chk("full_strobe_excl", viol, 0);

        // Mask 101: SA_3x3 skipped.
        run_seq(3'b101, 1, 1, 1, 0, 0, 0);
        chk("m101_start0", st_cyc[0], 2);
        chk("m101_valid0", val_cyc[0], 4);
        chk("m101_start2", st_cyc[2], 5);
        chk("m101_valid2", val_cyc[2], 7);
        chk("m101_sa3_start", st_cnt[1], 0);
        chk("m101_sa3_valid", val_cnt[1], 0);
        chk("m101_done_cyc", done_cyc, 8);

        // Empty mask: capture then straight to done.
        run_seq(3'b000, 1, 1, 1, 0, 0, 0);
        chk("m000_cap_cyc", cap_cyc, 1);
        chk("m000_done_cyc", done_cyc, 2);
        chk("m000_starts", st_cnt[0] + st_cnt[1] + st_cnt[2], 0);

        // SA_3x3 never finishes: 4 WAIT cycles (6..9), DONE in cycle 10.
        run_seq(3'b111, 1, 0, 1, 0, 0, 0);
        chk("to_done_cyc", done_cyc, 10);
        chk("to_err", err_done, 1);
        chk("to_err_idx", erridx_done, 1);
        chk("to_pe_valid", val_cnt[0], 1);
        chk("to_sa3_valid", val_cnt[1], 0);
        chk("to_sa2_valid", val_cnt[2], 0);
        chk("to_sa2_start", st_cnt[2], 0);
        chk("to_err_sticky", err_end, 1);

        // Done on the 4th (final) WAIT cycle wins over the timeout; also clears the previous error.
        run_seq(3'b010, 0, 4, 0, 0, 0, 0);
        chk("last_err_cleared", err_c2, 0);
        chk("last_start1", st_cyc[1], 2);
        chk("last_valid1", val_cyc[1], 7);
        chk("last_done_cyc", done_cyc, 8);
        chk("last_err", err_done, 0);

        // Extra start pulses during the run (including in DONE) are ignored.
        run_seq(3'b111, 1, 1, 1, 3, 11, 0);
        chk("xs_cap_cnt", cap_cnt, 1);
        chk("xs_done_cyc", done_cyc, 11);
        chk("xs_done_cnt", done_cnt, 1);

        // Reset while PE is in WAIT, then a clean run.
        run_seq(3'b001, 0, 0, 0, 0, 0, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            int'({capture_o, eng_start_o, pe_valid_o, sa3_valid_o, sa2_valid_o,
                  busy_o, done_o, err_o, err_idx_o, res_sel_o}), 0);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_o || pe_valid_o || (eng_start_o != 3'b000)) done_cnt++;
        end
        chk("rst_mid_no_activity", done_cnt, 0);
        run_seq(3'b111, 1, 1, 1, 0, 0, 0);
        chk("post_rst_cap_cyc", cap_cyc, 1);
        chk("post_rst_done_cyc", done_cyc, 11);
        chk("post_rst_valid2", val_cyc[2], 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
